icache_model: RTL and testbench

ICACHE_MODEL -- requirements
Module: icache_model

---
 rtl/mmm_pkg.sv | 11 +
 rtl/icache_model_queue.sv | 58 +++++
 rtl/icache_model.sv | 101 ++++++++++
 tb/tb_icache_model.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmm_pkg.sv
// Shared fetch-path widths and the instruction-cache response type.
package mmm_pkg;
  localparam int XLEN         = 32;
  localparam int ILEN         = 32;
  localparam int ICACHE_INSTR = 4;

  typedef struct packed {
    logic [XLEN-1:0]                    pc;
    logic [ICACHE_INSTR-1:0][ILEN-1:0]  line;
  } icache_out_t;
endpackage

// File: rtl/icache_model_queue.sv
// In-order circular request queue; writes on push_i, head is combinational from storage.
// Pointers wrap modulo DEPTH; flush_i clears the queue on the same edge.
module icache_model_queue #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 32,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [PW-1:0]    wr_ptr_o,
  output logic [PW-1:0]    rd_ptr_o,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_dat_o
);
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_mem [DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (pop_i)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the top never exposes an entry that was not written.
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr] <= push_dat_i;
  end

  assign wr_ptr_o   = r_wr_ptr;
  assign rd_ptr_o   = r_rd_ptr;
  assign count_o    = r_count;
  assign head_dat_o = r_mem[r_rd_ptr];
endmodule

// File: rtl/icache_model.sv
// Fixed-latency fetch responder: response LATENCY cycles after accept, in order, held until data_ready_i.
// ICACHE_MODEL_STALL_EN adds a periodic addr_ready_o drop every STALL_PERIOD cycles.
module icache_model
  import mmm_pkg::*;
#(
  parameter int LATENCY      = 2,
  parameter int DEPTH        = 4,
  parameter int STALL_PERIOD = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic            addr_valid_i,
  output logic            addr_ready_o,
  output icache_out_t     data_o,
  output logic            data_valid_o,
  input  logic            data_ready_i
);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int CDW  = 4;
  localparam int OFFW = $clog2(ICACHE_INSTR * 4);

  if (LATENCY < 1 || LATENCY > 15 || DEPTH < 1 || DEPTH > 16 || STALL_PERIOD < 2) begin : g_param_check
    $error("icache_model: parameter out of legal range");
  end

  logic [PW-1:0]   w_wr_ptr;
  logic [PW-1:0]   w_rd_ptr;
  logic [CW-1:0]   w_count;
  logic [XLEN-1:0] w_head_addr;
  logic [XLEN-1:0] w_base;
  logic            w_push;
  logic            w_pop;
  logic            w_valid;
  logic            w_stall;
  logic [CDW-1:0]  r_cd [DEPTH];

`ifdef ICACHE_MODEL_STALL_EN
  localparam int SW = $clog2(STALL_PERIOD);
  logic [SW-1:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                r_stall_cnt <= '0;
    else if (r_stall_cnt == SW'(STALL_PERIOD - 1)) r_stall_cnt <= '0;
    else                                         r_stall_cnt <= r_stall_cnt + SW'(1);
  end

  assign w_stall = (r_stall_cnt == SW'(STALL_PERIOD - 1));
`else
  assign w_stall = 1'b0;
`endif

  // Gating with rst_n_i keeps ready low throughout reset and high right after release.
  assign addr_ready_o = rst_n_i && (w_count < CW'(DEPTH)) && !flush_i && !w_stall;
  assign w_push       = addr_valid_i && addr_ready_o;
  assign w_valid      = (w_count != '0) && (r_cd[w_rd_ptr] == '0) && !flush_i;
  assign w_pop        = w_valid && data_ready_i;
  assign data_valid_o = w_valid;

  icache_model_queue #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_queue (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .flush_i    (flush_i),
    .push_i     (w_push),
    .push_dat_i (addr_i),
    .pop_i      (w_pop),
    .wr_ptr_o   (w_wr_ptr),
    .rd_ptr_o   (w_rd_ptr),
    .count_o    (w_count),
    .head_dat_o (w_head_addr)
  );

  // One countdown per slot; a slot reaching zero stays there until reloaded by a new push.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) r_cd[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (w_wr_ptr == PW'(i))) r_cd[i] <= CDW'(LATENCY - 1);
        else if (r_cd[i] != '0)             r_cd[i] <= r_cd[i] - CDW'(1);
      end
    end
  end

  assign w_base = {w_head_addr[XLEN-1:OFFW], {OFFW{1'b0}}};

  always_comb begin
    data_o = '0;
    if (w_valid) begin
      data_o.pc = w_head_addr;
      for (int i = 0; i < ICACHE_INSTR; i++) begin
        data_o.line[i] = w_base[ILEN-1:0] + ILEN'(4 * i);
      end
    end
  end
endmodule

// File: tb/tb_icache_model.sv
// Bench for icache_model (LATENCY=3, DEPTH=2, STALL_PERIOD=4) with an edge-index reference model.
module tb_icache_model;
  import mmm_pkg::*;

  localparam int L  = 3;
  localparam int D  = 2;
  localparam int SP = 4;
`ifdef ICACHE_MODEL_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] addr;
  logic        addr_valid;
  logic        addr_ready;
  icache_out_t data;
  logic        data_valid;
  logic        data_ready;

  always #5 clk = ~clk;

  icache_model #(
    .LATENCY      (L),
    .DEPTH        (D),
    .STALL_PERIOD (SP)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .flush_i      (flush),
    .addr_i       (addr),
    .addr_valid_i (addr_valid),
    .addr_ready_o (addr_ready),
    .data_o       (data),
    .data_valid_o (data_valid),
    .data_ready_i (data_ready)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic icache_out_t exp_out(input logic [31:0] a);
    icache_out_t r;
    r.pc = a;
    for (int i = 0; i < 4; i++) r.line[i] = (a & 32'hFFFF_FFF0) + 32'(4 * i);
    return r;
  endfunction

  // Reference model: each request remembers the edge index at which it was accepted.
  typedef struct { logic [31:0] a; int t; } req_t;
  req_t m_q[$];
  int   eidx = 0;

  function automatic logic m_ready();
    if (!rst_n || flush) return 1'b0;
    if (STALL && (eidx % SP == SP - 1)) return 1'b0;
    return m_q.size() < D;
  endfunction

  function automatic logic m_valid();
    if (!rst_n || flush || m_q.size() == 0) return 1'b0;
    return (m_q[0].t + L - 1) <= eidx;
  endfunction

  initial forever begin
    logic acc;
    logic pop;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      eidx = 0;
    end else begin
      acc = addr_valid && m_ready();
      pop = m_valid() && data_ready;
      eidx++;
      if (flush) m_q.delete();
      else begin
        if (pop) void'(m_q.pop_front());
        if (acc) m_q.push_back('{a: addr, t: eidx});
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("model_ready", addr_ready, m_ready());
      chk("model_valid", data_valid, m_valid());
      if (m_valid()) chk("model_data", data, exp_out(m_q[0].a));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic        r;
    logic        er;
    logic        ev;
    logic [31:0] epc;
  } vec_t;
  vec_t tbl[15];

  initial begin
    int w;
    int lat;
    tbl[0]  = '{1'b1, 32'h104, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h104};
    tbl[4]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 32'h10,  1'b0, 1'b1, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 32'h20,  1'b0, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 32'h20,  1'b0, 1'b0, 1'b1, 32'h0};
    tbl[9]  = '{1'b1, 32'h20,  1'b1, 1'b0, 1'b1, 32'h0};
    tbl[10] = '{1'b1, 32'h20,  1'b0, 1'b1, 1'b1, 32'h10};
    tbl[11] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h10};
    tbl[12] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h20};
    tbl[14] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0};

    rst_n = 1'b0; flush = 1'b0; addr = '0; addr_valid = 1'b0; data_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", addr_ready, 1'b0);
    chk("reset_valid", data_valid, 1'b0);
    chk("reset_data", data, '0);
    rst_n = 1'b1;

    // Table phase: row k is applied in cycle k after release.
    for (int k = 0; k < 15; k++) begin
      addr_valid = tbl[k].v; addr = tbl[k].a; data_ready = tbl[k].r;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", k), addr_ready, tbl[k].er && !(STALL && (k % SP == SP - 1)));
      chk($sformatf("tbl%0d_valid", k), data_valid, tbl[k].ev);
      if (tbl[k].ev) chk($sformatf("tbl%0d_data", k), data, exp_out(tbl[k].epc));
      tick();
    end
    addr_valid = 1'b0; data_ready = 1'b0;

    // Response held for 4 cycles without data_ready_i.
    addr_valid = 1'b1; addr = 32'h200;
    w = 0;
    while (!addr_ready && w < 10) begin tick(); w++; end
    tick();
    addr_valid = 1'b0;
    w = 0;
    while (!data_valid && w < 10) begin tick(); w++; end
    chk("hold_wait", data_valid, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_valid", data_valid, 1'b1);
      chk("hold_data", data, exp_out(32'h200));
      tick();
    end
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    @(negedge clk);
    chk("hold_popped", data_valid, 1'b0);
    tick();

    // Flush with two entries in flight.
    addr_valid = 1'b1; addr = 32'h300; tick();
    addr = 32'h310; tick();
    addr_valid = 1'b0; tick();
    flush = 1'b1; addr_valid = 1'b1; addr = 32'h999;
    @(negedge clk);
    chk("flush_ready", addr_ready, 1'b0);
    chk("flush_valid", data_valid, 1'b0);
    tick();
    flush = 1'b0; addr_valid = 1'b0; data_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flush_stale", data_valid, 1'b0);
      tick();
    end
    addr_valid = 1'b1; addr = 32'h40;
    w = 0;
    while (!addr_ready && w < 10) begin tick(); w++; end
    tick();
    addr_valid = 1'b0;
    lat = 1;
    while (!data_valid && lat < 10) begin tick(); lat++; end
    chk("flush_latency", lat, 3);
    chk("flush_new_pc", data.pc, 32'h40);
    tick();

    // Asynchronous reset mid-cycle with one request in flight.
    addr_valid = 1'b1; addr = 32'h500; data_ready = 1'b1;
    w = 0;
    while (!addr_ready && w < 10) begin tick(); w++; end
    tick();
    addr_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", addr_ready, 1'b0);
    chk("arst_valid", data_valid, 1'b0);
    chk("arst_data", data, '0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("release_ready", addr_ready, 1'b1);

    // Stall pattern after release with no traffic; also no stale response.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("stall_ready_c%0d", k), addr_ready, !(STALL && (k % SP == SP - 1)));
      chk("arst_stale", data_valid, 1'b0);
      tick();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      addr_valid = ($urandom_range(0, 9) < 7);
      addr       = $urandom;
      data_ready = ($urandom_range(0, 9) < 6);
      flush      = ($urandom_range(0, 31) == 0);
      tick();
    end
    addr_valid = 1'b0; flush = 1'b0; data_ready = 1'b1;
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
